div_share_arbiter: RTL and testbench
====================================

# div_share_arbiter

Shares one instance of the 16-bit combinational restoring divider (CombDivider16) between NUM_REQ requesters. Arbitration is round-robin. The block registers the winning operands and holds them stable for a programmable multicycle window, so the deep divider path is not timed in a single cycle. It then returns quotient, remainder, divide-by-zero flag and requester ID on a shared response channel with backpressure. It sits between the requesting engines and the divider, and is the only block that drives the divider's inputs.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of rsp_id. Must satisfy ID_W ≥ clog2(NUM_REQ).
- EXEC_CYCLES, 2: cycles the operands are held before the result is sampled, 1..15. Matches the multicycle constraint on the divider path.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept. One-hot or zero.
- req_lop  in  16*NUM_REQ  dividends. Requester i uses bits [16i+15:16i].
- req_rop  in  16*NUM_REQ  divisors, same packing as req_lop.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that the response belongs to.
- rsp_quot  out  16  quotient.
- rsp_mod  out  16  remainder.
- rsp_dz  out  1  divisor was zero.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready[g] = 1 for the round-robin winner g among the asserted req_valid. This is combinational from req_valid and the pointer.
  - On the clock edge where any request is valid:
    - latch lop_r, rop_r and id_r = g;
    - load the counter with EXEC_CYCLES-1;
    - move to EXEC;
    - set the pointer to (g+1) mod NUM_REQ.
- Round-robin search: start at the pointer and pick the first asserted index, wrapping around. When nothing is valid, the pointer holds its value.
- EXEC:
  - lop_r and rop_r drive the divider continuously; the registers are the only divider inputs.
  - The counter decrements once per cycle.
  - On the edge where the counter is 0:
    - capture quot into rsp_quot and mod into rsp_mod;
    - set rsp_dz = (rop_r == 0);
    - set rsp_id = id_r;
    - move to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_* stay stable until rsp_valid && rsp_ready. On that edge, go to IDLE.
  - req_ready is 0 in EXEC and RESP.
- Divide by zero: no special-casing. The divider's natural result is passed through, so quot = 0xFFFF and mod = lop, with rsp_dz = 1.
- Req inputs are sampled only on the accept edge. A requester may change or drop its inputs afterwards without effect.
- req_valid is expected to stay asserted until that requester sees req_ready. This is checked by assertion, not enforced by the block.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, pointer = 0, counter = 0;
  - rsp_valid = 0, rsp_id = 0, rsp_quot = 0, rsp_mod = 0, rsp_dz = 0;
  - busy = 0, and req_ready is forced to 0 while reset is high.
  - Reset in EXEC or RESP abandons the operation; no response is produced.
- Accept edge at cycle T: busy = 1 from T+1.
- rsp_valid rises at T+1+EXEC_CYCLES.
- With rsp_ready held high, the response handshake completes on the first rsp_valid cycle. IDLE resumes the following cycle and the next grant is possible in that cycle.
- Minimum request spacing is EXEC_CYCLES+2 cycles.
- rsp_ready low stalls in RESP indefinitely, with outputs held.
- A req_valid that rises while the block is busy waits; it is not dropped.
- Simultaneous requests: exactly one is granted per IDLE cycle. No requester waits more than NUM_REQ grants.
- Sampling instants:
  - divider outputs are sampled only at the end of the last EXEC cycle;
  - lop_r and rop_r change only on accept edges.

## Test plan
- Single request, EXEC_CYCLES=2: req0 lop=1000, rop=7 accepted at T. Required response at T+3: rsp_quot=142, rsp_mod=6, rsp_dz=0, rsp_id=0. busy is high from T+1 through T+3.
- Divide by zero: req2 lop=0x1234, rop=0. Required response: quot=0xFFFF, mod=0x1234, dz=1, id=2.
- All four requesters valid continuously from reset, each with distinct operands:
  - grants occur in the order 0,1,2,3,0;
  - each response matches its operands;
  - grants are spaced exactly 4 cycles apart.
- Backpressure: rsp_ready held low for 10 cycles while in RESP.
  - Required: rsp_valid stays high and rsp_quot, rsp_mod, rsp_id are stable; req_ready stays 0.
  - After rsp_ready rises: a single handshake, then IDLE.
- Boundary operands:
  - lop=0xFFFF, rop=1 → quot=0xFFFF, mod=0;
  - lop=5, rop=0xFFFF → quot=0, mod=5;
  - lop=0xFFFF, rop=0xFFFF → quot=1, mod=0.
- Reset mid-EXEC: assert reset one cycle after an accept.
  - Required: rsp_valid=0 and busy=0 immediately.
  - After release, the pointer is 0 and a new request from req1 completes normally with its own result.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin share of one combinational 16-bit restoring divider among NUM_REQ
// requesters. Operands are held for EXEC_CYCLES cycles so the divider path is multicycle.
`timescale 1ns/1ps

module comb_divider16 (
  input  logic [15:0] lop,
  input  logic [15:0] rop,
  output logic [15:0] quot,
  output logic [15:0] mod
);
  // A zero divisor is not special-cased: every step "fits", so quot = 0xFFFF and mod = lop
  always_comb begin
    logic [16:0] rem;
    logic [15:0] q;
    rem = '0;
    q   = '0;
    for (int i = 15; i >= 0; i--) begin
      rem = {rem[15:0], lop[i]};
      if (rem >= {1'b0, rop}) begin
        rem  = rem - {1'b0, rop};
        q[i] = 1'b1;
      end
    end
    quot = q;
    mod  = rem[15:0];
  end
endmodule

module div_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_lop,
  input  logic [16*NUM_REQ-1:0] req_rop,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_quot,
  output logic [15:0]           rsp_mod,
  output logic                  rsp_dz,
  output logic                  busy,
  output logic [1:0]            state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_valid must stay high until req_ready; rsp_* are held stable while rsp_valid && !rsp_ready.

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] grant_idx;
  logic             any_valid;
  logic [3:0]       cnt;
  logic [15:0]      lop_r;
  logic [15:0]      rop_r;
  logic [ID_W-1:0]  id_r;
  logic [15:0]      lop_sel;
  logic [15:0]      rop_sel;
  logic [15:0]      div_quot;
  logic [15:0]      div_mod;
  logic             load;
  logic             capture;

  // Round-robin search: first asserted index at or after ptr, wrapping around
  always_comb begin
    int idx;
    any_valid = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && req_valid[PTR_W'(idx)]) begin
        any_valid = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    lop_sel = '0;
    rop_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        lop_sel = req_lop[16*k +: 16];
        rop_sel = req_rop[16*k +: 16];
      end
    end
  end

  assign ptr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  comb_divider16 u_div (
    .lop  (lop_r),
    .rop  (rop_r),
    .quot (div_quot),
    .mod  (div_mod)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          load                 = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      lop_r    <= '0;
      rop_r    <= '0;
      id_r     <= '0;
      rsp_id   <= '0;
      rsp_quot <= '0;
      rsp_mod  <= '0;
      rsp_dz   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        lop_r <= lop_sel;
        rop_r <= rop_sel;
        id_r  <= ID_W'(grant_idx);
        cnt   <= CNT_LOAD;
        ptr   <= ptr_nxt;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 1'b1;
      end
      // Divider outputs are only looked at here, after the full multicycle window
      if (capture) begin
        rsp_quot <= div_quot;
        rsp_mod  <= div_mod;
        rsp_dz   <= (rop_r == 16'd0);
        rsp_id   <= id_r;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (reset)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized and directed bench for div_share_arbiter against a cycle-count,
// arithmetic reference model with an expected-response queue.
`timescale 1ns/1ps

module tb_div_share_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int EXEC_CYCLES = 2;
  localparam int RSP_W       = ID_W + 33;
  localparam int MODE_HOLD   = 0;
  localparam int MODE_DROP   = 1;
  localparam int MODE_RAND   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_lop;
  logic [16*NUM_REQ-1:0] req_rop;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_quot;
  logic [15:0]           rsp_mod;
  logic                  rsp_dz;
  logic                  busy;
  logic [1:0]            state_dbg;

  logic [15:0] lop_a [NUM_REQ];
  logic [15:0] rop_a [NUM_REQ];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb begin
    req_lop = '0;
    req_rop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_lop[16*i +: 16] = lop_a[i];
      req_rop[16*i +: 16] = rop_a[i];
    end
  end

  div_share_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .EXEC_CYCLES (EXEC_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lop   (req_lop),
    .req_rop   (req_rop),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_quot  (rsp_quot),
    .rsp_mod   (rsp_mod),
    .rsp_dz    (rsp_dz),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [RSP_W-1:0]   exp_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 cyc = 0;
  int                 acc_cyc = 0;
  int                 ptr_m = 0;
  int                 mode = MODE_DROP;
  logic [NUM_REQ-1:0] acc_last;
  logic [NUM_REQ-1:0] obs_acc;
  logic               obs_rv;
  logic               obs_busy;
  logic [RSP_W-1:0]   obs_rsp;
  int                 obs_cyc;
  int                 grant_id[$];
  int                 grant_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [RSP_W-1:0] ref_div(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q;
    logic [15:0] m;
    logic        dz;
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      m  = a;
      dz = 1'b1;
    end else begin
      q  = a / b;
      m  = a % b;
      dz = 1'b0;
    end
    return {ID_W'(id), dz, q, m};
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic apply_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      case (mode)
        MODE_DROP: if (acc_last[i]) req_valid[i] = 1'b0;
        MODE_RAND: begin
          if (acc_last[i] || !req_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              req_valid[i] = 1'b1;
              lop_a[i]     = rand_op();
              rop_a[i]     = rand_op();
            end else begin
              req_valid[i] = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
    if (mode == MODE_RAND) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // One clock: sample after inputs settle, compare to the model, advance model, then drive
  task automatic run_cycle();
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_rv;
    int                 g;
    #1;
    obs_rsp  = {rsp_id, rsp_dz, rsp_quot, rsp_mod};
    obs_rv   = rsp_valid;
    obs_busy = busy;
    obs_cyc  = cyc;
    obs_acc  = req_valid & req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (obs_acc[i]) begin
        grant_id.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    exp_ready = '0;
    if (reset) begin
      exp_q.delete();
      ptr_m = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_fields", obs_rsp, 0);
    end else begin
      exp_rv = (exp_q.size() != 0) && (cyc >= acc_cyc + 1 + EXEC_CYCLES);
      g = (exp_q.size() == 0) ? rr_pick(req_valid, ptr_m) : -1;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, exp_q.size() != 0);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) check("rsp_data", obs_rsp, exp_q[0]);
      if (exp_rv && rsp_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(ref_div(g, lop_a[g], rop_a[g]));
        acc_cyc = cyc;
        ptr_m   = (g + 1) % NUM_REQ;
      end
    end
    acc_last = obs_acc;
    cyc++;
    @(negedge clk);
    apply_drive();
  endtask

  task automatic wait_grant(output int gid, output int gc);
    bit done;
    done = 1'b0;
    gid  = -1;
    gc   = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      run_cycle();
      if (obs_acc != 0) begin
        done = 1'b1;
        gc   = obs_cyc;
        for (int i = 0; i < NUM_REQ; i++) if (obs_acc[i]) gid = i;
      end
    end
    check("grant_timeout", done, 1);
  endtask

  task automatic wait_rsp(output logic [RSP_W-1:0] r, output int rc);
    bit done;
    done = 1'b0;
    r    = '0;
    rc   = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      run_cycle();
      if (obs_rv) begin
        done = 1'b1;
        r    = obs_rsp;
        rc   = obs_cyc;
      end
    end
    check("rsp_timeout", done, 1);
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    mode      = MODE_DROP;
    rsp_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      run_cycle();
      if (!obs_busy && obs_acc == 0 && req_valid == 0) done = 1'b1;
    end
    check("drain_timeout", done, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] bl [3] = '{16'hFFFF, 16'd5,    16'hFFFF};
  logic [15:0] br [3] = '{16'd1,    16'hFFFF, 16'hFFFF};
  logic [15:0] bq [3] = '{16'hFFFF, 16'd0,    16'd1};
  logic [15:0] bm [3] = '{16'd0,    16'd5,    16'd0};

  initial begin
    int               gid;
    int               gc;
    int               rc;
    logic [RSP_W-1:0] r;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    acc_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lop_a[i] = '0;
      rop_a[i] = '0;
    end
    @(negedge clk);
    run_cycle();
    run_cycle();
    reset = 1'b0;

    // single request, fixed latency
    lop_a[0] = 16'd1000; rop_a[0] = 16'd7; req_valid[0] = 1'b1;
    wait_grant(gid, gc);
    check("t1_gid", gid, 0);
    wait_rsp(r, rc);
    check("t1_latency", rc - gc, EXEC_CYCLES + 1);
    check("t1_rsp", r, {2'd0, 1'b0, 16'd142, 16'd6});
    drain();

    // divide by zero
    lop_a[2] = 16'h1234; rop_a[2] = 16'd0; req_valid[2] = 1'b1;
    wait_rsp(r, rc);
    check("dz_rsp", r, {2'd2, 1'b1, 16'hFFFF, 16'h1234});
    drain();

    // boundary operands
    for (int k = 0; k < 3; k++) begin
      lop_a[3] = bl[k]; rop_a[3] = br[k]; req_valid[3] = 1'b1;
      wait_rsp(r, rc);
      check("bnd_quot", r[31:16], bq[k]);
      check("bnd_mod", r[15:0], bm[k]);
      check("bnd_id", r[RSP_W-1 -: ID_W], 3);
      drain();
    end

    // backpressure with other requesters waiting
    rsp_ready = 1'b0;
    lop_a[1] = 16'd500; rop_a[1] = 16'd9; req_valid[1] = 1'b1;
    wait_rsp(r, rc);
    check("bp_first", r, {2'd1, 1'b0, 16'd55, 16'd5});
    lop_a[0] = 16'd77; rop_a[0] = 16'd3; req_valid[0] = 1'b1;
    lop_a[2] = 16'd9;  rop_a[2] = 16'd2; req_valid[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      check("bp_rv_held", obs_rv, 1);
      check("bp_rsp_held", obs_rsp, {2'd1, 1'b0, 16'd55, 16'd5});
      check("bp_no_accept", obs_acc, 0);
    end
    rsp_ready = 1'b1;
    run_cycle();
    check("bp_release", obs_rv, 1);
    run_cycle();
    check("bp_idle_rv", obs_rv, 0);
    check("bp_next_grant", obs_acc, 4'b0100);
    drain();

    // all requesters valid continuously from reset
    reset = 1'b1;
    run_cycle();
    for (int i = 0; i < NUM_REQ; i++) begin
      lop_a[i] = 16'(1000 + 333 * i);
      rop_a[i] = 16'(3 + 4 * i);
    end
    req_valid = '1;
    mode      = MODE_HOLD;
    reset     = 1'b0;
    grant_id.delete();
    grant_cyc.delete();
    for (int k = 0; k < 40 && grant_id.size() < 5; k++) run_cycle();
    check("a4_count", grant_id.size(), 5);
    for (int k = 0; k < 5 && k < grant_id.size(); k++) check("a4_order", grant_id[k], k % NUM_REQ);
    for (int k = 1; k < grant_cyc.size(); k++) check("a4_spacing", grant_cyc[k] - grant_cyc[k-1], EXEC_CYCLES + 2);
    drain();

    // reset one cycle after an accept; pointer must restart at 0
    lop_a[1] = 16'd40; rop_a[1] = 16'd6; req_valid[1] = 1'b1;
    wait_grant(gid, gc);
    #1;
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_rv", rsp_valid, 0);
    run_cycle();
    reset = 1'b0;
    lop_a[1] = 16'd100; rop_a[1] = 16'd7; req_valid[1] = 1'b1;
    lop_a[3] = 16'd8;   rop_a[3] = 16'd8; req_valid[3] = 1'b1;
    wait_grant(gid, gc);
    check("rst_ptr_gid", gid, 1);
    wait_rsp(r, rc);
    check("rst_new_rsp", r, {2'd1, 1'b0, 16'd14, 16'd2});
    drain();

    // randomized traffic with random backpressure
    mode = MODE_RAND;
    repeat (600) run_cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
